// File: rtl/cplx_alu_pkg.sv
// Shared opcodes, FSM states and capture tags
// for the complex ALU sequencer.
package cplx_alu_pkg;

   localparam logic [1:0] OPC_NOP = 2'b00;
   localparam logic [1:0] OPC_SUB = 2'b01;
   localparam logic [1:0] OPC_ADD = 2'b10;
   localparam logic [1:0] OPC_MUL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      TAG_RE,
      TAG_IM,
      TAG_AC,
      TAG_BD,
      TAG_AD,
      TAG_BC
   } tag_t;

endpackage

// File: rtl/cplx_tag_pipe.sv
// Valid+tag shift register that lines up each issued
// scalar op with the cycle its ALU result is present.
module cplx_tag_pipe
   import cplx_alu_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  tag_t tag_in,
   output logic head_valid,
   output tag_t head_tag
);

   logic [DEPTH-1:0] vld;
   tag_t             tags [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++)
            tags[i] <= TAG_RE;
      end else begin
         vld     <= {vld[DEPTH-2:0], push};
         tags[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++)
            tags[i] <= tags[i-1];
      end
   end

   assign head_valid = vld[DEPTH-1];
   assign head_tag   = tags[DEPTH-1];

endmodule

// File: rtl/cplx_alu_sequencer.sv
// Runs complex ADD/SUB/MUL as a burst of scalar ops
// through one shared pipelined ALU.
module cplx_alu_sequencer
   import cplx_alu_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int ALU_W   = 2*OP_W,
   parameter int RES_W   = ALU_W+2,
   parameter int ALU_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [OP_W-1:0]  a_re,
   input  logic [OP_W-1:0]  a_im,
   input  logic [OP_W-1:0]  b_re,
   input  logic [OP_W-1:0]  b_im,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_re,
   output logic [RES_W-1:0] res_im,
   output logic             res_err,
   output logic [1:0]       alu_opcode,
   output logic [OP_W-1:0]  alu_op1,
   output logic [OP_W-1:0]  alu_op2,
   input  logic [ALU_W-1:0] alu_out,
   input  logic             alu_valid
);

   localparam int EXT = RES_W - ALU_W;

   state_t           state;
   logic [1:0]       op;
   logic [OP_W-1:0]  ar, ai, br, bi;
   logic [2:0]       cnt, last_cnt;
   logic [ALU_W-1:0] ac, ad;

   logic             accept, issue_now, push;
   logic             head_valid;
   tag_t             head_tag, iss_tag, tag_in;
   logic [OP_W-1:0]  iss_op1, iss_op2;
   logic [RES_W-1:0] out_s, out_z, ac_z, ad_z;

   assign accept    = (state == S_IDLE) && req_valid && req_ready;
   assign last_cnt  = (op == OPC_MUL) ? 3'd3 : 3'd1;
   assign issue_now = (state == S_ISSUE) && (cnt <= last_cnt);

   // First op is always (a_re,b_re): straight from the request.
   always_comb begin
      iss_op1 = ai;
      iss_op2 = bi;
      iss_tag = (op == OPC_MUL) ? TAG_BD : TAG_IM;
      unique case (1'b1)
         cnt == 3'd2: begin
            iss_op1 = ar;
            iss_op2 = bi;
            iss_tag = TAG_AD;
         end
         cnt == 3'd3: begin
            iss_op1 = ai;
            iss_op2 = br;
            iss_tag = TAG_BC;
         end
         default: ;
      endcase
   end

   assign push   = (accept && req_op != OPC_NOP) || issue_now;
   assign tag_in = !accept ? iss_tag :
                   (req_op == OPC_MUL) ? TAG_AC : TAG_RE;

   assign out_s = {{EXT{alu_out[ALU_W-1]}}, alu_out};
   assign out_z = {{EXT{1'b0}}, alu_out};
   assign ac_z  = {{EXT{1'b0}}, ac};
   assign ad_z  = {{EXT{1'b0}}, ad};

   cplx_tag_pipe #(
      .DEPTH (ALU_LAT+1)
   ) u_tags (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .tag_in     (tag_in),
      .head_valid (head_valid),
      .head_tag   (head_tag)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b0;
         res_valid  <= 1'b0;
         res_re     <= '0;
         res_im     <= '0;
         res_err    <= 1'b0;
         alu_opcode <= OPC_NOP;
         alu_op1    <= '0;
         alu_op2    <= '0;
         op         <= OPC_NOP;
         {ar, ai, br, bi} <= '0;
         cnt        <= '0;
         ac         <= '0;
         ad         <= '0;
      end else begin
         alu_opcode <= OPC_NOP;
         unique case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  op        <= req_op;
                  {ar, ai, br, bi} <= {a_re, a_im, b_re, b_im};
                  cnt       <= 3'd1;
                  res_re    <= '0;
                  res_im    <= '0;
                  res_err   <= 1'b0;
                  if (req_op == OPC_NOP) begin
                     state <= S_DONE;
                  end else begin
                     state      <= S_ISSUE;
                     alu_opcode <= req_op;
                     alu_op1    <= a_re;
                     alu_op2    <= b_re;
                  end
               end
            end
            S_ISSUE: begin
               if (issue_now) begin
                  alu_opcode <= op;
                  alu_op1    <= iss_op1;
                  alu_op2    <= iss_op2;
                  cnt        <= cnt + 3'd1;
               end else begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: ;
            S_DONE: begin
               if (!res_valid) begin
                  res_valid <= 1'b1;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (head_valid) begin
            if (!alu_valid)
               res_err <= 1'b1;
            case (head_tag)
               TAG_RE: res_re <= out_s;
               TAG_IM: begin
                  res_im    <= out_s;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end
               TAG_AC: ac <= alu_out;
               TAG_BD: res_re <= ac_z - out_z;
               TAG_AD: ad <= alu_out;
               TAG_BC: begin
                  res_im    <= ad_z + out_z;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cplx_alu_sequencer.sv
// Randomized and directed checks of cplx_alu_sequencer
// against a complex-arithmetic model and a 2-stage ALU model.
module tb_cplx_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [4:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [11:0] res_re, res_im;
   logic        res_err;
   logic [1:0]  alu_opcode;
   logic [4:0]  alu_op1, alu_op2;
   logic [9:0]  alu_out = '0;
   logic        alu_valid = 1'b0;

   int total = 0;
   int bad = 0;

   cplx_alu_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .a_re       (a_re),
      .a_im       (a_im),
      .b_re       (b_re),
      .b_im       (b_im),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_re     (res_re),
      .res_im     (res_im),
      .res_err    (res_err),
      .alu_opcode (alu_opcode),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_out    (alu_out),
      .alu_valid  (alu_valid)
   );

   always #5 clk = ~clk;

   // ALU model: input register then output register; can drop one valid.
   logic [1:0]  s_op = '0;
   logic [4:0]  s_a = '0, s_b = '0;
   logic        s_v = 1'b0;
   int          alu_n = 0;
   int          drop_at = -1;
   logic [13:0] iss_q [$];

   always @(posedge clk) begin
      s_op <= alu_opcode;
      s_a  <= alu_op1;
      s_b  <= alu_op2;
      s_v  <= (alu_opcode != 2'b00) && (alu_n + 1 != drop_at);
      if (alu_opcode != 2'b00) begin
         alu_n <= alu_n + 1;
         iss_q.push_back({2'b00, alu_opcode, alu_op1, alu_op2});
      end
      case (s_op)
         2'b01:   alu_out <= {5'b0, s_a} - {5'b0, s_b};
         2'b10:   alu_out <= {5'b0, s_a} + {5'b0, s_b};
         2'b11:   alu_out <= {5'b0, s_a} * {5'b0, s_b};
         default: alu_out <= '0;
      endcase
      alu_valid <= s_v;
   end

   function automatic void model(input logic [1:0] op,
                                 input int ar, input int ai,
                                 input int br, input int bi,
                                 output logic [11:0] er,
                                 output logic [11:0] ei,
                                 output int lat);
      int r, i;
      case (op)
         2'b01:   begin r = ar - br; i = ai - bi; lat = 4; end
         2'b10:   begin r = ar + br; i = ai + bi; lat = 4; end
         2'b11:   begin
            r = ar*br - ai*bi;
            i = ar*bi + ai*br;
            lat = 6;
         end
         default: begin r = 0; i = 0; lat = 1; end
      endcase
      er = r[11:0];
      ei = i[11:0];
   endfunction

   // Drives one request from #1 after an edge; returns edges to res_valid.
   task automatic send(input logic [1:0] op,
                       input logic [4:0] ar, input logic [4:0] ai,
                       input logic [4:0] br, input logic [4:0] bi,
                       output int lat);
      int w;
      w = 0;
      lat = -1;
      while (!req_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      req_op = op;
      {a_re, a_im, b_re, b_im} = {ar, ai, br, bi};
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (res_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({req_ready, res_valid, res_err} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags got %b want 000",
                  {req_ready, res_valid, res_err});
      end
      total++;
      if ({alu_opcode, alu_op1, alu_op2, res_re, res_im} !== '0) begin
         bad++;
         $display("FAIL reset_data got op=%b re=%h im=%h want 0",
                  alu_opcode, res_re, res_im);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got %b want 1", req_ready);
      end
   endtask

   task automatic test_directed();
      int lat, n0;
      send(2'b10, 5'd3, 5'd4, 5'd5, 5'd6, lat);
      total++;
      if ({lat[3:0], res_re, res_im, res_err} !== {4'd4, 12'd8, 12'd10, 1'b0}) begin
         bad++;
         $display("FAIL add_dir got lat=%0d %h %h err=%b want 4 008 00a 0",
                  lat, res_re, res_im, res_err);
      end
      handshake();
      send(2'b01, 5'd2, 5'd1, 5'd5, 5'd7, lat);
      total++;
      if ({lat[3:0], res_re, res_im} !== {4'd4, 12'hFFD, 12'hFFA}) begin
         bad++;
         $display("FAIL sub_dir got lat=%0d %h %h want 4 ffd ffa",
                  lat, res_re, res_im);
      end
      handshake();
      n0 = iss_q.size();
      send(2'b11, 5'd3, 5'd2, 5'd1, 5'd4, lat);
      total++;
      if ({lat[3:0], res_re, res_im} !== {4'd6, 12'hFFB, 12'h00E}) begin
         bad++;
         $display("FAIL mul_dir got lat=%0d %h %h want 6 ffb 00e",
                  lat, res_re, res_im);
      end
      total++;
      if (iss_q.size() != n0 + 4 ||
          iss_q[n0]   !== {4'b0011, 5'd3, 5'd1} ||
          iss_q[n0+1] !== {4'b0011, 5'd2, 5'd4} ||
          iss_q[n0+2] !== {4'b0011, 5'd3, 5'd4} ||
          iss_q[n0+3] !== {4'b0011, 5'd2, 5'd1}) begin
         bad++;
         $display("FAIL mul_order got %0d ops want 4 ac,bd,ad,bc",
                  iss_q.size() - n0);
      end
      handshake();
      send(2'b11, 5'd31, 5'd31, 5'd31, 5'd31, lat);
      total++;
      if ({res_re, res_im} !== {12'h000, 12'h782}) begin
         bad++;
         $display("FAIL mul_max got %h %h want 000 782", res_re, res_im);
      end
      handshake();
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [4:0]  ar, ai, br, bi;
      logic [11:0] er, ei;
      int          lat, elat;
      for (int n = 0; n < 16; n++) begin
         op = 2'($urandom_range(0, 3));
         ar = 5'($urandom_range(0, 31));
         ai = 5'($urandom_range(0, 31));
         br = 5'($urandom_range(0, 31));
         bi = 5'($urandom_range(0, 31));
         model(op, int'(ar), int'(ai), int'(br), int'(bi), er, ei, elat);
         send(op, ar, ai, br, bi, lat);
         total++;
         if (lat != elat) begin
            bad++;
            $display("FAIL rand_lat op=%0d got %0d want %0d", op, lat, elat);
         end
         total++;
         if ({res_re, res_im, res_err} !== {er, ei, 1'b0}) begin
            bad++;
            $display("FAIL rand_res op=%0d got %h %h err=%b want %h %h 0",
                     op, res_re, res_im, res_err, er, ei);
         end
         handshake();
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] er, ei;
      int          lat, elat, n0;
      model(2'b11, 7, 9, 30, 2, er, ei, elat);
      send(2'b11, 5'd7, 5'd9, 5'd30, 5'd2, lat);
      req_op = 2'b10;
      req_valid = 1'b1;
      n0 = iss_q.size();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         total++;
         if ({res_valid, req_ready, res_re, res_im} !== {2'b10, er, ei}) begin
            bad++;
            $display("FAIL hold c%0d got v=%b rdy=%b %h %h want 1 0 %h %h",
                     k, res_valid, req_ready, res_re, res_im, er, ei);
         end
      end
      total++;
      if (iss_q.size() != n0) begin
         bad++;
         $display("FAIL hold_noissue got %0d ops want 0", iss_q.size() - n0);
      end
      req_valid = 1'b0;
      handshake();
      total++;
      if ({req_ready, res_valid} !== 2'b10) begin
         bad++;
         $display("FAIL post_hs got rdy=%b v=%b want 1 0", req_ready, res_valid);
      end
      send(2'b10, 5'd20, 5'd1, 5'd11, 5'd30, lat);
      total++;
      if ({lat[3:0], res_re, res_im} !== {4'd4, 12'd31, 12'd31}) begin
         bad++;
         $display("FAIL b2b got lat=%0d %h %h want 4 01f 01f",
                  lat, res_re, res_im);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      int lat;
      req_op = 2'b11;
      {a_re, a_im, b_re, b_im} = {5'd9, 5'd8, 5'd7, 5'd6};
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      total++;
      if ({req_ready, res_valid, res_err, alu_opcode, res_re, res_im} !== '0) begin
         bad++;
         $display("FAIL reset_mid got rdy=%b v=%b op=%b %h %h want all 0",
                  req_ready, res_valid, alu_opcode, res_re, res_im);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      send(2'b10, 5'd1, 5'd1, 5'd1, 5'd1, lat);
      total++;
      if ({lat[3:0], res_re, res_im, res_err} !== {4'd4, 12'd2, 12'd2, 1'b0}) begin
         bad++;
         $display("FAIL after_reset got lat=%0d %h %h err=%b want 4 002 002 0",
                  lat, res_re, res_im, res_err);
      end
      handshake();
   endtask

   task automatic test_err_nop();
      int lat, n0;
      drop_at = alu_n + 2;
      send(2'b10, 5'd12, 5'd13, 5'd14, 5'd15, lat);
      drop_at = -1;
      total++;
      if ({res_err, res_re, res_im} !== {1'b1, 12'd26, 12'd28}) begin
         bad++;
         $display("FAIL err_flag got err=%b %h %h want 1 01a 01c",
                  res_err, res_re, res_im);
      end
      handshake();
      n0 = iss_q.size();
      send(2'b00, 5'd5, 5'd6, 5'd7, 5'd8, lat);
      total++;
      if ({lat[3:0], res_re, res_im, res_err} !== {4'd1, 24'd0, 1'b0}) begin
         bad++;
         $display("FAIL nop got lat=%0d %h %h err=%b want 1 000 000 0",
                  lat, res_re, res_im, res_err);
      end
      handshake();
      total++;
      if (iss_q.size() != n0) begin
         bad++;
         $display("FAIL nop_noalu got %0d ops want 0", iss_q.size() - n0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_err_nop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
